// File: rtl/hub75_frame_streamer_if.sv
// ============================================================================
// Module   : hub75_frame_streamer_if
// Purpose  : valid/ready word stream between the frame streamer and the HUB75 loader.
// Options  : HUB75_STREAMER_LAST_EN adds the end-of-frame 'last' flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hub75_frame_streamer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
`ifdef HUB75_STREAMER_LAST_EN
  logic                  last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
`else
  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
`endif
endinterface

`default_nettype wire

// File: rtl/hub75_frame_streamer.sv
// ============================================================================
// Module   : hub75_frame_streamer
// Purpose  : reads one packed frame from a synchronous frame RAM and streams it
//            as words through a 2-entry output FIFO on a valid/ready master port.
// Options  : HUB75_STREAMER_LAST_EN adds m_axi.last on the final word of a frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hub75_frame_streamer #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 9,
  parameter int WORDS_PER_FRAME = 384,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_start,
  input  logic                       i_loop,
  output logic                       o_busy,
  output logic                       o_frame_done,
  output logic [FRAME_CNT_WIDTH-1:0] o_frame_count,
  output logic                       o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]      o_mem_addr,
  input  logic [DATA_WIDTH-1:0]      i_mem_rd_data,
  hub75_frame_streamer_if.master     m_axi
);

  // One extra bit so a frame of exactly 2**ADDR_WIDTH words can be counted.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] c_WORDS    = CW'(WORDS_PER_FRAME);
  localparam logic [CW-1:0] c_LAST_IDX = CW'(WORDS_PER_FRAME - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                     r_state;
  logic                       r_busy;
  logic                       r_frame_done;
  logic [FRAME_CNT_WIDTH-1:0] r_frame_count;
  logic [CW-1:0]              r_rd_addr;
  logic [CW-1:0]              r_xfer_cnt;
  logic                       r_inflight;
  logic [DATA_WIDTH-1:0]      r_fifo_data [2];
  logic                       r_wr_ptr;
  logic                       r_rd_ptr;
  logic [1:0]                 r_count;

  logic                       w_pop;
  logic [2:0]                 w_occ;
  logic                       w_rd_en;
  logic                       w_last_xfer;

  assign w_pop       = m_axi.valid & m_axi.ready;
  assign w_occ       = {1'b0, r_count} + {2'b00, r_inflight};
  // Issue only if the FIFO can still absorb this read once it lands next cycle.
  assign w_rd_en     = (r_state == ST_STREAM) && (r_rd_addr < c_WORDS) &&
                       (w_occ <= ({2'b00, w_pop} + 3'd1));
  assign w_last_xfer = w_pop && (r_xfer_cnt == c_LAST_IDX);

  assign o_mem_rd_en   = w_rd_en;
  assign o_mem_addr    = w_rd_en ? r_rd_addr[ADDR_WIDTH-1:0] : '0;
  assign o_busy        = r_busy;
  assign o_frame_done  = r_frame_done;
  assign o_frame_count = r_frame_count;
  assign m_axi.valid   = (r_count != 2'd0);
  assign m_axi.data    = r_fifo_data[r_rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_rd_addr     <= '0;
      r_xfer_cnt    <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_STREAM;
            r_busy  <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (w_rd_en) begin
            r_rd_addr <= r_rd_addr + 1'b1;
          end
          if (w_pop) begin
            if (w_last_xfer) begin
              r_state       <= ST_DONE;
              r_frame_done  <= 1'b1;
              r_frame_count <= r_frame_count + 1'b1;
              r_xfer_cnt    <= '0;
              r_rd_addr     <= '0;
            end else begin
              r_xfer_cnt <= r_xfer_cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (i_loop) begin
            r_state <= ST_STREAM;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight     <= 1'b0;
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_count        <= 2'd0;
    end else begin
      r_inflight <= w_rd_en;
      if (r_inflight) begin
        r_fifo_data[r_wr_ptr] <= i_mem_rd_data;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

`ifdef HUB75_STREAMER_LAST_EN
  logic r_inflight_last;
  logic r_fifo_last [2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight_last <= 1'b0;
      r_fifo_last[0]  <= 1'b0;
      r_fifo_last[1]  <= 1'b0;
    end else begin
      r_inflight_last <= w_rd_en && (r_rd_addr == c_LAST_IDX);
      if (r_inflight) begin
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
      end
    end
  end

  assign m_axi.last = (r_count != 2'd0) && r_fifo_last[r_rd_ptr];
`endif

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(r_inflight && !w_pop && (r_count == 2'd2)));

endmodule

`default_nettype wire

// File: tb/tb_hub75_frame_streamer.sv
// ============================================================================
// Module   : tb_hub75_frame_streamer
// Purpose  : randomized self-checking bench for hub75_frame_streamer against a
//            word-order / frame-count reference model (HUB75_STREAMER_LAST_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hub75_frame_streamer;

  localparam int DW  = 32;
  localparam int AW  = 3;
  localparam int WPF = 8;
  localparam int FCW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           loop_i;
  logic           busy;
  logic           frame_done;
  logic [FCW-1:0] frame_count;
  logic           mem_rd_en;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_rd_data;

  hub75_frame_streamer_if #(.DATA_WIDTH(DW)) axi ();

  hub75_frame_streamer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS_PER_FRAME(WPF), .FRAME_CNT_WIDTH(FCW)
  ) dut (
    .clk(clk), .reset(reset), .i_start(start), .i_loop(loop_i),
    .o_busy(busy), .o_frame_done(frame_done), .o_frame_count(frame_count),
    .o_mem_rd_en(mem_rd_en), .o_mem_addr(mem_addr), .i_mem_rd_data(mem_rd_data),
    .m_axi(axi)
  );

  always #5 clk = ~clk;

  // Frame RAM: data valid exactly one cycle after the read strobe, garbage otherwise.
  logic [DW-1:0] ram [WPF];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_addr];
    else           mem_rd_data <= 32'hDEAD_BEEF;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Ready driver: random 50% or a fixed level, updated just after each rising edge.
  bit   rand_ready = 1'b0;
  logic ready_val  = 1'b0;
  initial axi.ready = 1'b0;
  always @(posedge clk) begin
    #1;
    axi.ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
  end

  // Reference model: word k of every frame is ram[k]; frames counted modulo 2**FCW.
  int            exp_idx   = 0;
  int            model_fc  = 0;
  int            xfer_total = 0;
  int            done_total = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  bit            prev_last_xfer = 1'b0;
  bit            chk_fc = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      exp_idx        = 0;
      model_fc       = 0;
      prev_stall     = 1'b0;
      prev_last_xfer = 1'b0;
      chk_fc         = 1'b0;
    end else begin
      if (prev_stall) begin
        check_val("stall_valid", 64'(axi.valid), 64'd1);
        check_val("stall_data", 64'(axi.data), 64'(prev_data));
      end
      check_val("frame_done_timing", 64'(frame_done), 64'(prev_last_xfer));
      if (chk_fc) check_val("frame_count", 64'(frame_count), 64'(model_fc));
      chk_fc         = frame_done;
      prev_last_xfer = 1'b0;
`ifdef HUB75_STREAMER_LAST_EN
      if (axi.valid) check_val("last_flag", 64'(axi.last), 64'(exp_idx == WPF - 1));
`endif
      if (axi.valid && axi.ready) begin
        check_val("word", 64'(axi.data), 64'(ram[exp_idx]));
        if (exp_idx == WPF - 1) begin
          prev_last_xfer = 1'b1;
          model_fc       = (model_fc + 1) % (1 << FCW);
          done_total++;
        end
        exp_idx = (exp_idx + 1) % WPF;
        xfer_total++;
      end
      prev_stall = axi.valid && !axi.ready;
      prev_data  = axi.data;
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = frame_done;
    end
    check_val("done_timeout", 64'(seen), 64'd1);
  endtask

  task automatic randomize_ram();
    for (int i = 0; i < WPF; i++) ram[i] = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_x;
    int base_d;
    bit ok;
    for (int i = 0; i < WPF; i++) ram[i] = 32'h100 + i;
    reset = 1'b1; start = 1'b0; loop_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_valid", 64'(axi.valid), 64'd0);
    check_val("rst_done", 64'(frame_done), 64'd0);
    check_val("rst_fcount", 64'(frame_count), 64'd0);
    check_val("rst_rd_en", 64'(mem_rd_en), 64'd0);
    reset = 1'b0;
    ready_val = 1'b1;
    repeat (2) @(negedge clk);

    // Directed frame: latency, no bubbles, done pulse
    pulse_start();
    check_val("lat_c1_valid", 64'(axi.valid), 64'd0);
    check_val("lat_c1_rd_en", 64'(mem_rd_en), 64'd1);
    check_val("lat_c1_addr", 64'(mem_addr), 64'd0);
    check_val("lat_c1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check_val("lat_c2_valid", 64'(axi.valid), 64'd0);
    @(negedge clk);
    check_val("lat_c3_valid", 64'(axi.valid), 64'd1);
    for (int i = 1; i < WPF; i++) begin
      @(negedge clk);
      check_val("no_bubble", 64'(axi.valid), 64'd1);
    end
    @(negedge clk);
    check_val("done_pulse", 64'(frame_done), 64'd1);
    @(negedge clk);
    check_val("f1_count", 64'(frame_count), 64'd1);
    check_val("f1_idle", 64'(busy), 64'd0);
    check_val("f1_done_low", 64'(frame_done), 64'd0);

    // Random back-pressure over 3 frames
    randomize_ram();
    rand_ready = 1'b1;
    base_x = xfer_total; base_d = done_total;
    for (int f = 0; f < 3; f++) begin
      pulse_start();
      wait_done(400);
    end
    @(negedge clk);
    check_val("rand_words", 64'(xfer_total - base_x), 64'(3 * WPF));
    check_val("rand_frames", 64'(done_total - base_d), 64'd3);

    // Loop mode: two back-to-back frames
    randomize_ram();
    rand_ready = 1'b0; ready_val = 1'b1; loop_i = 1'b1;
    base_d = done_total;
    pulse_start();
    wait_done(200);
    check_val("loop_busy_done", 64'(busy), 64'd1);
    @(negedge clk);
    loop_i = 1'b0;
    check_val("loop_busy_restart", 64'(busy), 64'd1);
    check_val("loop_rd_en", 64'(mem_rd_en), 64'd1);
    check_val("loop_addr0", 64'(mem_addr), 64'd0);
    wait_done(200);
    @(negedge clk);
    check_val("loop_frames", 64'(done_total - base_d), 64'd2);
    check_val("loop_idle", 64'(busy), 64'd0);

    // start while streaming is ignored
    randomize_ram();
    rand_ready = 1'b1;
    base_x = xfer_total; base_d = done_total;
    pulse_start();
    repeat (5) @(negedge clk);
    pulse_start();
    wait_done(400);
    repeat (40) @(negedge clk);
    check_val("busy_start_words", 64'(xfer_total - base_x), 64'(WPF));
    check_val("busy_start_frames", 64'(done_total - base_d), 64'd1);
    check_val("busy_start_idle", 64'(busy), 64'd0);

    // Asynchronous reset mid-frame under back-pressure
    rand_ready = 1'b0; ready_val = 1'b1;
    base_x = xfer_total;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = (xfer_total - base_x) >= 3;
    end
    check_val("three_words_timeout", 64'(ok), 64'd1);
    ready_val = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("arst_valid", 64'(axi.valid), 64'd0);
    check_val("arst_busy", 64'(busy), 64'd0);
    check_val("arst_rd_en", 64'(mem_rd_en), 64'd0);
    check_val("arst_fcount", 64'(frame_count), 64'd0);
    check_val("arst_data", 64'(axi.data), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ready_val = 1'b1;
    base_x = xfer_total;
    pulse_start();
    check_val("arst_restart_addr", 64'(mem_addr), 64'd0);
    wait_done(200);
    @(negedge clk);
    check_val("arst_new_frame_words", 64'(xfer_total - base_x), 64'(WPF));
    check_val("arst_fcount_one", 64'(frame_count), 64'd1);

    // frame_count wrap over 4 looped frames (1 -> 2 -> 3 -> 0 -> 1)
    randomize_ram();
    rand_ready = 1'b1; loop_i = 1'b1;
    pulse_start();
    for (int f = 0; f < 3; f++) wait_done(400);
    @(negedge clk);
    check_val("wrap_to_zero", 64'(frame_count), 64'd0);
    loop_i = 1'b0;
    wait_done(400);
    @(negedge clk);
    check_val("wrap_after", 64'(frame_count), 64'd1);
    check_val("wrap_idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
